// File: rtl/identity_output_checker_if.sv
// rtl/identity_output_checker_if.sv - stimulus/result bundle between bench and identity output checker
interface identity_output_checker_if #(
    parameter int WIDTH = 166,
    parameter int CNT_W = 16
);
    logic             start;
    logic             sample_en;
    logic [WIDTH-1:0] y_ref;
    logic [WIDTH-1:0] y_dut;
    logic             busy;
    logic             done;
    logic             pass;
    logic             x_seen;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] mismatch_count;
    logic [CNT_W-1:0] first_mm_index;
    logic [WIDTH-1:0] first_mm_xor;
    logic [WIDTH-1:0] sig_ref;
    logic [WIDTH-1:0] sig_dut;

    modport master (
        output start, sample_en, y_ref, y_dut,
        input  busy, done, pass, x_seen, sample_count, mismatch_count,
               first_mm_index, first_mm_xor, sig_ref, sig_dut
    );

    modport slave (
        input  start, sample_en, y_ref, y_dut,
        output busy, done, pass, x_seen, sample_count, mismatch_count,
               first_mm_index, first_mm_xor, sig_ref, sig_dut
    );
endinterface

// File: rtl/identity_output_checker.sv
// rtl/identity_output_checker.sv - compares RTL vs netlist output buses, counts mismatches, builds MISR signatures
module identity_output_checker #(
    parameter int               WIDTH       = 166,
    parameter int               CNT_W       = 16,
    parameter int               NUM_SAMPLES = 22,
    parameter logic [WIDTH-1:0] POLY        = 1
) (
    input logic                    clk,
    input logic                    rst_n,
    identity_output_checker_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    logic [1:0]       state;
    logic             busy_r;
    logic             done_r;
    logic             x_seen_r;
    logic [CNT_W-1:0] sample_count_r;
    logic [CNT_W-1:0] mismatch_count_r;
    logic [CNT_W-1:0] first_mm_index_r;
    logic [WIDTH-1:0] first_mm_xor_r;
    logic [WIDTH-1:0] sig_ref_r;
    logic [WIDTH-1:0] sig_dut_r;

    logic mm;
    logic xin;

    // 4-state compare: any X/Z difference counts as a mismatch in simulation
    assign mm  = (bus.y_ref !== bus.y_dut);
    assign xin = $isunknown(bus.y_ref) || $isunknown(bus.y_dut);

    function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] sig,
                                                   input logic [WIDTH-1:0] y);
        return ({sig[WIDTH-2:0], 1'b0} ^ (sig[WIDTH-1] ? POLY : '0)) ^ y;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            x_seen_r         <= 1'b0;
            sample_count_r   <= '0;
            mismatch_count_r <= '0;
            first_mm_index_r <= '1;
            first_mm_xor_r   <= '0;
            sig_ref_r        <= '0;
            sig_dut_r        <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    // a sample_en coinciding with start is deliberately dropped
                    if (bus.start) begin
                        state            <= S_RUN;
                        busy_r           <= 1'b1;
                        done_r           <= 1'b0;
                        x_seen_r         <= 1'b0;
                        sample_count_r   <= '0;
                        mismatch_count_r <= '0;
                        first_mm_index_r <= '1;
                        first_mm_xor_r   <= '0;
                        sig_ref_r        <= '0;
                        sig_dut_r        <= '0;
                    end
                end
                S_RUN: begin
                    if (bus.sample_en) begin
                        sample_count_r <= sample_count_r + CNT_W'(1);
                        sig_ref_r      <= misr_next(sig_ref_r, bus.y_ref);
                        sig_dut_r      <= misr_next(sig_dut_r, bus.y_dut);
                        if (xin) begin
                            x_seen_r <= 1'b1;
                        end
                        if (mm) begin
                            if (mismatch_count_r != CNT_MAX) begin
                                mismatch_count_r <= mismatch_count_r + CNT_W'(1);
                            end
                            // mismatch_count saturates, so zero reliably marks "no mismatch yet"
                            if (mismatch_count_r == '0) begin
                                first_mm_index_r <= sample_count_r;
                                first_mm_xor_r   <= bus.y_ref ^ bus.y_dut;
                            end
                        end
                        if (sample_count_r == LAST_IDX) begin
                            state  <= S_DONE;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy           = busy_r;
    assign bus.done           = done_r;
    assign bus.pass           = done_r && (mismatch_count_r == '0) && !x_seen_r;
    assign bus.x_seen         = x_seen_r;
    assign bus.sample_count   = sample_count_r;
    assign bus.mismatch_count = mismatch_count_r;
    assign bus.first_mm_index = first_mm_index_r;
    assign bus.first_mm_xor   = first_mm_xor_r;
    assign bus.sig_ref        = sig_ref_r;
    assign bus.sig_dut        = sig_dut_r;
endmodule

// File: tb/tb_identity_output_checker.sv
// tb/tb_identity_output_checker.sv - table-driven scoreboard bench for identity_output_checker
module tb_identity_output_checker;
    localparam int W  = 166;
    localparam int CW = 16;
    localparam int NS = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    identity_output_checker_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    identity_output_checker #(
        .WIDTH(W), .CNT_W(CW), .NUM_SAMPLES(NS), .POLY(166'd1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int cnt;
        int mm;
        bit busy;
        bit done;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string name;
        int    fault_idx;
        int    fault_bit;
        bit    gaps;
        bit    mid_start;
        int    exp_mm;
        int    exp_first;
        bit    exp_pass;
    } row_t;

    logic [W-1:0] vecs[NS];

    bit           m_run, m_done, m_x;
    int           m_cnt, m_mm, m_first;
    logic [W-1:0] m_xor, m_sig_ref, m_sig_dut;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // POLY=1 makes the MISR a left rotate followed by XOR with the input
    function automatic logic [W-1:0] misr(input logic [W-1:0] s, input logic [W-1:0] y);
        return {s[W-2:0], s[W-1]} ^ y;
    endfunction

    task automatic model_clear();
        m_cnt = 0; m_mm = 0; m_first = 65535; m_xor = '0;
        m_sig_ref = '0; m_sig_dut = '0; m_x = 1'b0;
    endtask

    task automatic step(input string name, input logic [W-1:0] yr, input logic [W-1:0] yd,
                        input bit en, input bit st);
        exp_t e;
        bus.y_ref = yr; bus.y_dut = yd; bus.sample_en = en; bus.start = st;
        if (st && !m_run) begin
            model_clear();
            m_run = 1'b1; m_done = 1'b0;
        end else if (m_run && en) begin
            if ($isunknown(yr) || $isunknown(yd)) m_x = 1'b1;
            if (yr !== yd) begin
                if (m_mm == 0) begin
                    m_first = m_cnt;
                    m_xor = yr ^ yd;
                end
                m_mm++;
            end
            m_sig_ref = misr(m_sig_ref, yr);
            m_sig_dut = misr(m_sig_dut, yd);
            m_cnt++;
            if (m_cnt == NS) begin
                m_run = 1'b0; m_done = 1'b1;
            end
        end
        sbq.push_back('{m_cnt, m_mm, m_run, m_done});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk({name, ".sample_count"}, bus.sample_count, e.cnt);
        chk({name, ".mismatch_count"}, bus.mismatch_count, e.mm);
        chk({name, ".busy"}, bus.busy, e.busy);
        chk({name, ".done"}, bus.done, e.done);
        bus.start = 1'b0; bus.sample_en = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.sample_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m_run = 1'b0; m_done = 1'b0;
        model_clear();
        rst_n = 1'b1;
    endtask

    task automatic check_reset(input string name);
        chk({name, ".busy"}, bus.busy, 0);
        chk({name, ".done"}, bus.done, 0);
        chk({name, ".pass"}, bus.pass, 0);
        chk({name, ".x_seen"}, bus.x_seen, 0);
        chk({name, ".sample_count"}, bus.sample_count, 0);
        chk({name, ".mismatch_count"}, bus.mismatch_count, 0);
        chk({name, ".first_mm_index"}, bus.first_mm_index, 16'hFFFF);
        chk({name, ".first_mm_xor"}, bus.first_mm_xor, 0);
        chk({name, ".sig_ref"}, bus.sig_ref, 0);
        chk({name, ".sig_dut"}, bus.sig_dut, 0);
    endtask

    task automatic check_final(input string name, input int exp_mm, input int exp_first,
                               input bit exp_pass, input logic [W-1:0] exp_xor);
        chk({name, ".done_final"}, bus.done, 1);
        chk({name, ".count_final"}, bus.sample_count, NS);
        chk({name, ".mm_final"}, bus.mismatch_count, exp_mm);
        chk({name, ".first_idx"}, bus.first_mm_index, exp_first);
        chk({name, ".first_xor"}, bus.first_mm_xor, exp_xor);
        chk({name, ".pass"}, bus.pass, exp_pass);
        chk({name, ".x_seen"}, bus.x_seen, m_x);
        chk({name, ".sig_ref"}, bus.sig_ref, m_sig_ref);
        chk({name, ".sig_dut"}, bus.sig_dut, m_sig_dut);
        chk({name, ".sig_differs"}, bus.sig_ref !== bus.sig_dut, exp_mm != 0);
    endtask

    task automatic run_row(input row_t r);
        logic [W-1:0] yd;
        logic [W-1:0] junk;
        logic [W-1:0] exp_xor;
        int k;
        junk = ~vecs[0];
        // sample_en with differing data on the start cycle must not be taken
        step({r.name, ".start"}, vecs[0], junk, 1'b1, 1'b1);
        k = 0;
        for (int slot = 0; slot < 2 * NS; slot++) begin
            if (k >= NS) break;
            if (r.gaps && (slot % 2 == 1)) begin
                step({r.name, ".gap"}, vecs[k], junk, 1'b0, 1'b0);
            end else begin
                yd = vecs[k];
                if (k == r.fault_idx) yd[r.fault_bit] = ~yd[r.fault_bit];
                step({r.name, ".s"}, vecs[k], yd, 1'b1, r.mid_start && (k == 11));
                k++;
            end
        end
        // further samples in DONE are ignored and done holds
        step({r.name, ".after_done"}, vecs[1], junk, 1'b1, 1'b0);
        exp_xor = '0;
        if (r.fault_idx >= 0) exp_xor[r.fault_bit] = 1'b1;
        check_final(r.name, r.exp_mm, r.exp_first, r.exp_pass, exp_xor);
    endtask

    row_t rows[5];

    initial begin
        logic [W-1:0] xd;
        logic [W-1:0] xr;
        rows[0] = '{"ident",      -1,   0, 1'b0, 1'b0, 0, 65535, 1'b1};
        rows[1] = '{"fault5b7",    5,   7, 1'b0, 1'b0, 1, 5,     1'b0};
        rows[2] = '{"fault0b165",  0, 165, 1'b0, 1'b0, 1, 0,     1'b0};
        rows[3] = '{"fault21b0",  21,   0, 1'b0, 1'b0, 1, 21,    1'b0};
        rows[4] = '{"gaps",        3, 100, 1'b1, 1'b1, 1, 3,     1'b0};

        for (int k = 0; k < NS; k++)
            for (int b = 0; b < W; b++)
                vecs[k][b] = 1'($urandom_range(0, 1));

        bus.start = 1'b0; bus.sample_en = 1'b0; bus.y_ref = '0; bus.y_dut = '0;

        do_reset();
        check_reset("reset");
        step("idle_sample", vecs[0], ~vecs[0], 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) run_row(rows[i]);

        // X on y_dut[0] at sample 0; y_ref[0] forced to 1 so it differs in 2-state sims too
        xr = vecs[0]; xr[0] = 1'b1;
        xd = vecs[0]; xd[0] = 1'bx;
        step("xrun.start", vecs[0], vecs[0], 1'b0, 1'b1);
        step("xrun.s0", xr, xd, 1'b1, 1'b0);
        for (int k = 1; k < NS; k++) step("xrun.s", vecs[k], vecs[k], 1'b1, 1'b0);
        chk("xrun.mm", bus.mismatch_count, 1);
        chk("xrun.pass", bus.pass, 0);
        chk("xrun.x_seen", bus.x_seen, m_x);
        chk("xrun.first_idx", bus.first_mm_index, 0);
        chk("xrun.first_xor", bus.first_mm_xor, m_xor);

        step("rstrun.start", vecs[0], vecs[0], 1'b0, 1'b1);
        for (int k = 0; k <= 10; k++) step("rstrun.s", vecs[k], ~vecs[k], 1'b1, 1'b0);
        do_reset();
        check_reset("midrun_reset");
        run_row(rows[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
